fb_avl_arbiter: RTL
===================

Name: fb_avl_arbiter

Overview:
- Shares one Avalon-MM DDR2 framebuffer port between two requesters.
- Write requester: camera FIFO into the framebuffer. Read requester: framebuffer into the ADV output FIFO.
- Grants whole bursts, drives command, address and size to the memory controller, and counts beats to burst completion.
- Sits between the top-level image capture controller and each framebuffer's memory controller. It replaces free-running burst time-slicing with request-driven arbitration.

Parameters:
- ADDR_W, 25: width of burst start addresses and avl_addr.
- BURST_W, 5: width of avl_size and the beat counters. Must hold WR_BURST and RD_BURST.
- WR_BURST, 16: beats per write burst.
- RD_BURST, 16: beats per read burst.
- RD_TIMEOUT, 255: maximum consecutive S_RD_WAIT cycles without avl_rdata_valid before abort.

Ports:
- clk  in  1  system clock (50.4 MHz framebuffer domain).
- reset  in  1  synchronous, active-low reset.
- wr_req  in  1  write requester holds at least WR_BURST words, show-ahead.
- wr_addr  in  ADDR_W  write burst start address; sampled at grant.
- rd_req  in  1  read requester has room for at least RD_BURST words.
- rd_addr  in  ADDR_W  read burst start address; sampled at grant.
- avl_ready  in  1  memory controller accepts the current command/beat.
- avl_rdata_valid  in  1  one read beat returned.
- avl_write_req  out  1  write beat valid.
- avl_read_req  out  1  read command valid.
- avl_burstbegin  out  1  first cycle of a command.
- avl_addr  out  ADDR_W  latched burst address.
- avl_size  out  BURST_W  latched burst length.
- wr_pop  out  1  pop the camera FIFO; equals avl_write_req & avl_ready.
- wr_grant  out  1  high throughout a write burst.
- rd_grant  out  1  high from read command through last returned beat.
- wr_done  out  1  one-cycle pulse after the last write beat is accepted.
- rd_done  out  1  one-cycle pulse on the last read beat.
- rd_timeout  out  1  sticky read-abort flag.

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous, active-low.
- Reset values: state=S_IDLE, last_gnt=RD, all counters and latched address/size 0, every output 0. Reset mid-burst aborts immediately; no done pulse.
- States: S_IDLE, S_WR_BURST, S_RD_CMD, S_RD_WAIT. Encoding is binary, with a default arm back to S_IDLE.
- S_IDLE arbitration is evaluated every cycle:
  - Only wr_req: write wins.
  - Only rd_req: read wins.
  - Both: grant the side not equal to last_gnt (round-robin).
  - On grant, latch the address and size (WR_BURST or RD_BURST) and move to the target state next cycle.
  - Request-to-command latency is 1 cycle.
- S_WR_BURST:
  - wr_grant=1; avl_write_req=1 every cycle.
  - avl_burstbegin=1 only while beat count is 0.
  - Beat counter increments on avl_write_req & avl_ready; avl_ready low stalls with outputs held.
  - When beat WR_BURST-1 is accepted: wr_done=1 next cycle, last_gnt=WR, return to S_IDLE.
  - wr_req deasserting mid-burst is ignored.
- S_RD_CMD:
  - rd_grant=1; avl_read_req=1 and avl_burstbegin=1 until avl_ready, then move to S_RD_WAIT.
  - Exactly one command is issued per burst.
- S_RD_WAIT:
  - rd_grant=1. Count avl_rdata_valid beats.
  - On beat RD_BURST: rd_done=1 in that same cycle (combinational from the counter compare), last_gnt=RD, return to S_IDLE.
  - An idle counter clears on every valid beat and increments otherwise.
  - At RD_TIMEOUT: set rd_timeout (cleared only by reset), return to S_IDLE with no rd_done and last_gnt=RD.
- No back-to-back commands: at least one S_IDLE cycle separates bursts.
- avl_rdata_valid outside S_RD_WAIT is ignored.
- Address and size are never recomputed mid-burst. Changes on wr_addr or rd_addr during a burst have no effect.
- Counters use BURST_W bits and never wrap within a burst. The RD_TIMEOUT counter is 8 bits and saturates.

Optional Feature:
- Macro: FB_ARB_RD_PRIORITY_EN.
- When defined: in S_IDLE with both requests, read always wins regardless of last_gnt, protecting HDMI scan-out from underflow. Write is granted only when rd_req=0.
- When undefined: round-robin as above.

Test Plan:
- Only wr_req=1, wr_addr=0x100, avl_ready=1 -> avl_write_req high 16 consecutive cycles, burstbegin only on the first, avl_addr=0x100, avl_size=16, 16 wr_pop, wr_done one cycle after the last beat.
- Only rd_req=1, rd_addr=0x200, avl_ready low 3 cycles then high, 16 rdata_valid with gaps -> read_req held 4 cycles, single command, rd_done on the 16th valid beat, then S_IDLE.
- wr_req=rd_req=1 held for 4 bursts (macro undefined) -> grant order W,R,W,R. With FB_ARB_RD_PRIORITY_EN -> R,R,R,R.
- Read command accepted, then no rdata_valid for 255 cycles -> rd_timeout=1 sticky, no rd_done, a following wr_req is granted.
- reset=0 asserted at write beat 7 -> next cycle all outputs 0, state S_IDLE. A new write after release issues a full 16 beats.
- avl_ready toggled every other cycle during a write -> exactly 16 wr_pop and address/size stable throughout.

Source files
------------

// File: rtl/fb_avl_arbiter.sv
// fb_avl_arbiter
//   Shares one Avalon-MM DDR2 framebuffer port between a write requester
//   (camera FIFO -> framebuffer) and a read requester (framebuffer -> ADV
//   output FIFO). Whole bursts are granted. The granted burst's address and
//   size are latched and driven to the memory controller, and beats are
//   counted until the burst completes.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   wr_req, wr_addr     write requester: >= WR_BURST words ready, start address
//   rd_req, rd_addr     read requester: room for >= RD_BURST words, start address
//   avl_ready           controller accepts current command / write beat
//   avl_rdata_valid     one read beat returned
//   avl_write_req       write beat valid
//   avl_read_req        read command valid
//   avl_burstbegin      first cycle of a command
//   avl_addr, avl_size  latched burst address and length
//   wr_pop              pop camera FIFO (avl_write_req & avl_ready)
//   wr_grant, rd_grant  burst ownership
//   wr_done, rd_done    burst completion pulses
//   rd_timeout          sticky read-abort flag, cleared only by reset
//
// Build option
//   FB_ARB_RD_PRIORITY_EN: when defined, read always wins a simultaneous
//   request. When undefined, simultaneous requests alternate round-robin.

module fb_avl_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int BURST_W    = 5,
  parameter int WR_BURST   = 16,
  parameter int RD_BURST   = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic               avl_ready,
  input  logic               avl_rdata_valid,
  output logic               avl_write_req,
  output logic               avl_read_req,
  output logic               avl_burstbegin,
  output logic [ADDR_W-1:0]  avl_addr,
  output logic [BURST_W-1:0] avl_size,
  output logic               wr_pop,
  output logic               wr_grant,
  output logic               rd_grant,
  output logic               wr_done,
  output logic               rd_done,
  output logic               rd_timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_CMD   = 2'd2,
    S_RD_WAIT  = 2'd3
  } state_t;

  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  localparam logic [BURST_W-1:0] WR_SIZE  = BURST_W'(WR_BURST);
  localparam logic [BURST_W-1:0] RD_SIZE  = BURST_W'(RD_BURST);
  localparam logic [BURST_W-1:0] WR_LAST  = BURST_W'(WR_BURST - 1);
  localparam logic [BURST_W-1:0] RD_LAST  = BURST_W'(RD_BURST - 1);
  localparam logic [BURST_W-1:0] BEAT_ONE = BURST_W'(1);
  // The idle count reaching RD_TIMEOUT-1 with no beat this cycle means this
  // is the RD_TIMEOUT-th consecutive empty wait cycle.
  localparam logic [7:0]         IDLE_LAST = 8'(RD_TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic                last_gnt_reg, last_gnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [BURST_W-1:0]  size_reg, size_next;
  logic [BURST_W-1:0]  beat_reg, beat_next;
  logic [7:0]          idle_reg, idle_next;
  logic                timeout_reg, timeout_next;
  logic                wr_done_reg, wr_done_next;
  logic                grant_wr, grant_rd;
  logic                rd_last;

  // Arbitration between simultaneous requests
  always_comb begin
`ifdef FB_ARB_RD_PRIORITY_EN
    grant_wr = wr_req & ~rd_req;
`else
    grant_wr = wr_req & (~rd_req | (last_gnt_reg == GNT_RD));
`endif
    grant_rd = rd_req & ~grant_wr;
  end

  assign rd_last = (state_reg == S_RD_WAIT) & avl_rdata_valid & (beat_reg == RD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      last_gnt_reg <= GNT_RD;
      addr_reg     <= '0;
      size_reg     <= '0;
      beat_reg     <= '0;
      idle_reg     <= '0;
      timeout_reg  <= 1'b0;
      wr_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      beat_reg     <= beat_next;
      idle_reg     <= idle_next;
      timeout_reg  <= timeout_next;
      wr_done_reg  <= wr_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    addr_next     = addr_reg;
    size_next     = size_reg;
    beat_next     = beat_reg;
    idle_next     = idle_reg;
    timeout_next  = timeout_reg;
    wr_done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        beat_next = '0;
        idle_next = '0;
        if (grant_wr) begin
          state_next = S_WR_BURST;
          addr_next  = wr_addr;
          size_next  = WR_SIZE;
        end else if (grant_rd) begin
          state_next = S_RD_CMD;
          addr_next  = rd_addr;
          size_next  = RD_SIZE;
        end
      end
      S_WR_BURST: begin
        if (avl_ready) begin
          if (beat_reg == WR_LAST) begin
            state_next    = S_IDLE;
            last_gnt_next = GNT_WR;
            wr_done_next  = 1'b1;
            beat_next     = '0;
          end else begin
            beat_next = beat_reg + BEAT_ONE;
          end
        end
      end
      S_RD_CMD: begin
        if (avl_ready) begin
          state_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (avl_rdata_valid) begin
          idle_next = '0;
          if (rd_last) begin
            state_next    = S_IDLE;
            last_gnt_next = GNT_RD;
            beat_next     = '0;
          end else begin
            beat_next = beat_reg + BEAT_ONE;
          end
        end else if (idle_reg == IDLE_LAST) begin
          // Abort: controller stopped returning data
          state_next    = S_IDLE;
          last_gnt_next = GNT_RD;
          timeout_next  = 1'b1;
          beat_next     = '0;
          idle_next     = '0;
        end else if (idle_reg != 8'hFF) begin
          idle_next = idle_reg + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    avl_write_req  = (state_reg == S_WR_BURST);
    avl_read_req   = (state_reg == S_RD_CMD);
    avl_burstbegin = ((state_reg == S_WR_BURST) && (beat_reg == '0)) ||
                     (state_reg == S_RD_CMD);
    avl_addr       = addr_reg;
    avl_size       = size_reg;
    wr_pop         = (state_reg == S_WR_BURST) & avl_ready;
    wr_grant       = (state_reg == S_WR_BURST);
    rd_grant       = (state_reg == S_RD_CMD) || (state_reg == S_RD_WAIT);
    wr_done        = wr_done_reg;
    rd_done        = rd_last;
    rd_timeout     = timeout_reg;
  end

endmodule
